enigma_rotor_inverter: RTL

ENIGMA_ROTOR_INVERTER -- requirements
Module: enigma_rotor_inverter

---
 rtl/enigma_rotor_inverter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/enigma_rotor_inverter.sv
// Inverts a 26-entry ASCII rotor wiring table one entry per cycle.
// Optional ROTOR_PERM_CHECK_EN adds a seen mask that flags duplicate and missing letters.
module enigma_rotor_inverter #(
    parameter int ALPHA_BASE = 65
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [207:0] idx_in,
    output logic [207:0] inv_out,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [1:0]   state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, MAP = 2'd1, FINISH = 2'd2} state_t;

    localparam logic [7:0] BASE8 = ALPHA_BASE[7:0];

    state_t       state_q, state_d;
    logic [4:0]   k_q, k_d;
    logic         fetch_end_q, fetch_end_d;
    logic         pend_q, pend_d;
    logic [7:0]   pv_q, pv_d;
    logic [4:0]   pk_q, pk_d;
    logic [207:0] tbl_q, tbl_d;
    logic [207:0] inv_q, inv_d;
    logic         err_q, err_d;
`ifdef ROTOR_PERM_CHECK_EN
    logic [25:0]  seen_q, seen_d;
`endif

    logic [7:0] fetch_v;
    logic [7:0] off;
    logic       in_range;

    // Entry lookup is registered into pv_q/pk_q so the 26-way read mux and the
    // 26-way write decode sit in separate cycles.
    always_comb begin
        fetch_v = 8'h00;
        for (int j = 0; j < 26; j++) begin
            if (k_q == 5'(j)) fetch_v = tbl_q[j*8 +: 8];
        end
    end

    assign off      = pv_q - BASE8;
    assign in_range = (pv_q >= BASE8) && (off <= 8'd25);

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        fetch_end_d = fetch_end_q;
        pend_d      = pend_q;
        pv_d        = pv_q;
        pk_d        = pk_q;
        tbl_d       = tbl_q;
        inv_d       = inv_q;
        err_d       = err_q;
`ifdef ROTOR_PERM_CHECK_EN
        seen_d      = seen_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    tbl_d       = idx_in;
                    inv_d       = '0;
                    err_d       = 1'b0;
                    k_d         = 5'd0;
                    fetch_end_d = 1'b0;
                    pend_d      = 1'b0;
`ifdef ROTOR_PERM_CHECK_EN
                    seen_d      = '0;
`endif
                    state_d     = MAP;
                end
            end
            MAP: begin
                if (!fetch_end_q) begin
                    pv_d   = fetch_v;
                    pk_d   = k_q;
                    pend_d = 1'b1;
                    if (k_q == 5'd25) fetch_end_d = 1'b1;
                    else              k_d = k_q + 5'd1;
                end else begin
                    pend_d = 1'b0;
                end
                if (pend_q) begin
                    if (in_range) begin
                        for (int j = 0; j < 26; j++) begin
                            if (off[4:0] == 5'(j)) begin
                                inv_d[j*8 +: 8] = BASE8 + {3'b000, pk_q};
`ifdef ROTOR_PERM_CHECK_EN
                                if (seen_q[j]) err_d = 1'b1;
                                seen_d[j] = 1'b1;
`endif
                            end
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                    if (pk_q == 5'd25) state_d = FINISH;
                end
            end
            FINISH: begin
`ifdef ROTOR_PERM_CHECK_EN
                err_d = err_q | ~(&seen_q);
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            k_q         <= 5'd0;
            fetch_end_q <= 1'b0;
            pend_q      <= 1'b0;
            pv_q        <= 8'h00;
            pk_q        <= 5'd0;
            tbl_q       <= '0;
            inv_q       <= '0;
            err_q       <= 1'b0;
`ifdef ROTOR_PERM_CHECK_EN
            seen_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            fetch_end_q <= fetch_end_d;
            pend_q      <= pend_d;
            pv_q        <= pv_d;
            pk_q        <= pk_d;
            tbl_q       <= tbl_d;
            inv_q       <= inv_d;
            err_q       <= err_d;
`ifdef ROTOR_PERM_CHECK_EN
            seen_q      <= seen_d;
`endif
        end
    end

    assign inv_out   = inv_q;
    assign busy      = (state_q == MAP);
    assign done      = (state_q == FINISH);
    assign state_dbg = state_q;
`ifdef ROTOR_PERM_CHECK_EN
    // Missing letters are only known once all entries are in, so fold them in during FINISH.
    assign err = err_q | ((state_q == FINISH) & ~(&seen_q));
`else
    assign err = err_q;
`endif

endmodule
